// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - state encoding, RV32I opcodes and select encodings for the multi-cycle sequencer
package seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_t;

  typedef enum logic [3:0] {
    CLS_ALU_R,
    CLS_ALU_I,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JAL,
    CLS_JALR,
    CLS_LUI,
    CLS_AUIPC,
    CLS_SYSTEM,
    CLS_ILLEGAL
  } op_class_t;

  localparam logic [6:0] OP_ALU_R  = 7'b0110011;
  localparam logic [6:0] OP_ALU_I  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JAL    = 2'b10;
  localparam logic [1:0] PC_JALR   = 2'b11;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_PC4 = 2'b10;
  localparam logic [1:0] WD_IMM = 2'b11;

  localparam int TIMEOUT_DEF = 15;

endpackage

// File: rtl/seq_op_class.sv
// rtl/seq_op_class.sv - combinational RV32I opcode-to-class decoder
module seq_op_class
  import seq_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_t  op_class
);

  always_comb begin
    op_class = CLS_ILLEGAL;
    case (opcode)
      OP_ALU_R:  op_class = CLS_ALU_R;
      OP_ALU_I:  op_class = CLS_ALU_I;
      OP_LOAD:   op_class = CLS_LOAD;
      OP_STORE:  op_class = CLS_STORE;
      OP_BRANCH: op_class = CLS_BRANCH;
      OP_JAL:    op_class = CLS_JAL;
      OP_JALR:   op_class = CLS_JALR;
      OP_LUI:    op_class = CLS_LUI;
      OP_AUIPC:  op_class = CLS_AUIPC;
      OP_SYSTEM: op_class = CLS_SYSTEM;
      default:   op_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multi_cycle_sequencer.sv
// rtl/multi_cycle_sequencer.sv - multi-cycle RV32I control FSM with memory timeout
// SEQ_PERF_CNT_EN adds cycle_cnt/instret_cnt performance counters.
module multi_cycle_sequencer
  import seq_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TO_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       br_taken,
  output logic       imem_req,
  input  logic       imem_ack,
  output logic       dmem_req,
  output logic       dmem_we,
  input  logic       dmem_ack,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       a_select,
  output logic       b_select,
  output logic       reg_write,
  output logic [1:0] wd_src,
  output logic       illegal,
  output logic       bus_err,
  output logic       halt
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);

  state_t          state;
  op_class_t       op_cls;
  op_class_t       cls_q;
  logic [TO_W-1:0] to_cnt;
  logic            illegal_q;
  logic            bus_err_q;

  seq_op_class u_op_class (
    .opcode   (opcode),
    .op_class (op_cls)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cls_q     <= CLS_ILLEGAL;
      to_cnt    <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: state <= ST_FETCH;
        ST_FETCH: begin
          if (imem_ack) begin
            state  <= ST_DECODE;
            to_cnt <= '0;
          end else if (to_cnt == TO_MAX) begin
            state     <= ST_HALT;
            bus_err_q <= 1'b1;
            to_cnt    <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_DECODE: begin
          // The class is latched so EXEC/MEM/WB do not depend on opcode staying put.
          cls_q <= op_cls;
          if (op_cls == CLS_SYSTEM) begin
            state <= ST_HALT;
          end else if (op_cls == CLS_ILLEGAL) begin
            state     <= ST_HALT;
            illegal_q <= 1'b1;
          end else begin
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (cls_q)
            CLS_BRANCH:          state <= ST_FETCH;
            CLS_LOAD, CLS_STORE: state <= ST_MEM;
            default:             state <= ST_WB;
          endcase
        end
        ST_MEM: begin
          if (dmem_ack) begin
            state  <= (cls_q == CLS_STORE) ? ST_FETCH : ST_WB;
            to_cnt <= '0;
          end else if (to_cnt == TO_MAX) begin
            state     <= ST_HALT;
            bus_err_q <= 1'b1;
            to_cnt    <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_WB:   state <= ST_FETCH;
        ST_HALT: state <= ST_HALT;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Strobes are suppressed while rst is high so a reset never lands a partial write.
  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_PLUS4;
    a_select  = 1'b0;
    b_select  = 1'b0;
    reg_write = 1'b0;
    wd_src    = WD_ALU;
    if (!rst) begin
      case (state)
        ST_FETCH: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            pc_src   = PC_PLUS4;
          end
        end
        ST_EXEC: begin
          case (cls_q)
            CLS_BRANCH: begin
              a_select = 1'b1;
              b_select = 1'b1;
              if (br_taken) begin
                pc_write = 1'b1;
                pc_src   = PC_BRANCH;
              end
            end
            CLS_JAL: begin
              pc_write = 1'b1;
              pc_src   = PC_JAL;
            end
            CLS_JALR: begin
              pc_write = 1'b1;
              pc_src   = PC_JALR;
            end
            CLS_LOAD, CLS_STORE, CLS_ALU_I: b_select = 1'b1;
            CLS_AUIPC: begin
              a_select = 1'b1;
              b_select = 1'b1;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (cls_q == CLS_STORE);
        end
        ST_WB: begin
          reg_write = 1'b1;
          case (cls_q)
            CLS_LOAD:          wd_src = WD_MEM;
            CLS_JAL, CLS_JALR: wd_src = WD_PC4;
            CLS_LUI:           wd_src = WD_IMM;
            default:           wd_src = WD_ALU;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign illegal = illegal_q;
  assign bus_err = bus_err_q;
  assign halt    = (state == ST_HALT);

`ifdef SEQ_PERF_CNT_EN
  logic retire;
  assign retire = ((state == ST_EXEC) && (cls_q == CLS_BRANCH)) ||
                  ((state == ST_MEM) && dmem_ack && (cls_q == CLS_STORE)) ||
                  (state == ST_WB);

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state != ST_IDLE && state != ST_HALT) cycle_cnt <= cycle_cnt + 32'd1;
      if (retire) instret_cnt <= instret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multi_cycle_sequencer.sv
// tb/tb_multi_cycle_sequencer.sv - table-driven bench for multi_cycle_sequencer
module tb_multi_cycle_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic       br_taken = 1'b0;
  logic       imem_req, imem_ack = 1'b0;
  logic       dmem_req, dmem_we, dmem_ack = 1'b0;
  logic       ir_write, pc_write, a_select, b_select, reg_write;
  logic [1:0] pc_src, wd_src;
  logic       illegal, bus_err, halt;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  multi_cycle_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .opcode    (opcode),
    .br_taken  (br_taken),
    .imem_req  (imem_req),
    .imem_ack  (imem_ack),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .dmem_ack  (dmem_ack),
    .ir_write  (ir_write),
    .pc_write  (pc_write),
    .pc_src    (pc_src),
    .a_select  (a_select),
    .b_select  (b_select),
    .reg_write (reg_write),
    .wd_src    (wd_src),
    .illegal   (illegal),
    .bus_err   (bus_err),
    .halt      (halt)
`ifdef SEQ_PERF_CNT_EN
    ,
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] op;
    logic       br;
    int         idel;
    int         ddel;
    int         cyc;
    int         rw;
    int         wd;
    int         pcw;
    int         src;
    int         a;
    int         b;
    int         dreq;
    int         we;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs[NV];

  int checks = 0;
  int errors = 0;
  int i_delay = 0, d_delay = 0, i_wait = 0, d_wait = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [14:0] outs();
    return {imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src,
            a_select, b_select, reg_write, wd_src, illegal, bus_err, halt};
  endfunction

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  // Memory responder: ack once req has been held for the programmed number of extra cycles.
  task automatic drive_acks();
    if (imem_req) begin
      imem_ack = (i_wait >= i_delay);
      i_wait++;
    end else begin
      imem_ack = 1'b0;
      i_wait = 0;
    end
    if (dmem_req) begin
      dmem_ack = (d_wait >= d_delay);
      d_wait++;
    end else begin
      dmem_ack = 1'b0;
      d_wait = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    i_wait = 0;
    d_wait = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'(outs()), 32'd0);
    rst = 1'b0;
    #3;
    check("idle_outputs", 32'(outs()), 32'd0);
    advance();
  endtask

  // Entered at the start of a FETCH cycle before acks are driven; returns at the next one.
  task automatic run_instr(input vec_t v, input int idx);
    int c = 0, k = -1, rw_n = 0, wd = 0, ir_n = 0, dreq_n = 0, we_bad = 0;
    int ex_pcw = -1, ex_src = -1, ex_a = -1, ex_b = -1;
    bit seen_low = 0, done = 0;
    opcode = v.op;
    br_taken = v.br;
    i_delay = v.idel;
    d_delay = v.ddel;
    check($sformatf("v%0d_fetch_start", idx), 32'(imem_req), 32'd1);
    while (!done && c < 60) begin
      drive_acks();
      #3;
      if (k < 0 && imem_req && imem_ack) k = c;
      if (ir_write) ir_n++;
      if (k >= 0 && c == k + 2) begin
        ex_pcw = int'(pc_write);
        ex_src = int'(pc_src);
        ex_a = int'(a_select);
        ex_b = int'(b_select);
      end
      if (reg_write) begin
        rw_n++;
        wd = int'(wd_src);
      end
      if (dmem_req) begin
        dreq_n++;
        if (int'(dmem_we) != v.we) we_bad++;
      end else if (dmem_we) begin
        we_bad++;
      end
      c++;
      advance();
      if (!imem_req) seen_low = 1;
      else if (seen_low) done = 1;
    end
    check($sformatf("v%0d_cycles", idx), 32'(c), 32'(v.cyc));
    check($sformatf("v%0d_ir_write", idx), 32'(ir_n), 32'd1);
    check($sformatf("v%0d_reg_write", idx), 32'(rw_n), 32'(v.rw));
    check($sformatf("v%0d_wd_src", idx), 32'(wd), 32'(v.wd));
    check($sformatf("v%0d_exec_pc_write", idx), 32'(ex_pcw), 32'(v.pcw));
    check($sformatf("v%0d_exec_pc_src", idx), 32'(ex_src), 32'(v.src));
    check($sformatf("v%0d_exec_a_select", idx), 32'(ex_a), 32'(v.a));
    check($sformatf("v%0d_exec_b_select", idx), 32'(ex_b), 32'(v.b));
    check($sformatf("v%0d_dmem_req_cycles", idx), 32'(dreq_n), 32'(v.dreq));
    check($sformatf("v%0d_dmem_we", idx), 32'(we_bad), 32'd0);
  endtask

  initial begin
    int n, bad;
    bit found;
    //          op          br    idel ddel cyc rw wd pcw src a  b  dreq we
    vecs[0]  = '{7'b0110011, 1'b0, 1,   0,   5,  1, 0, 0,  0,  0, 0, 0,   0};
    vecs[1]  = '{7'b0000011, 1'b0, 0,   3,   8,  1, 1, 0,  0,  0, 1, 4,   0};
    vecs[2]  = '{7'b1100011, 1'b1, 0,   0,   3,  0, 0, 1,  1,  1, 1, 0,   0};
    vecs[3]  = '{7'b1100011, 1'b0, 0,   0,   3,  0, 0, 0,  0,  1, 1, 0,   0};
    vecs[4]  = '{7'b0100011, 1'b0, 0,   0,   4,  0, 0, 0,  0,  0, 1, 1,   1};
    vecs[5]  = '{7'b0010011, 1'b0, 0,   0,   4,  1, 0, 0,  0,  0, 1, 0,   0};
    vecs[6]  = '{7'b1101111, 1'b0, 0,   0,   4,  1, 2, 1,  2,  0, 0, 0,   0};
    vecs[7]  = '{7'b1100111, 1'b0, 0,   0,   4,  1, 2, 1,  3,  0, 0, 0,   0};
    vecs[8]  = '{7'b0110111, 1'b0, 0,   0,   4,  1, 3, 0,  0,  0, 0, 0,   0};
    vecs[9]  = '{7'b0010111, 1'b0, 0,   0,   4,  1, 0, 0,  0,  1, 1, 0,   0};
    vecs[10] = '{7'b0100011, 1'b0, 0,   2,   6,  0, 0, 0,  0,  0, 1, 3,   1};
    vecs[11] = '{7'b0110011, 1'b0, 15,  0,   19, 1, 0, 0,  0,  0, 0, 0,   0};

    do_reset();
`ifdef SEQ_PERF_CNT_EN
    check("perf_cycle_reset", cycle_cnt, 32'd0);
    check("perf_instret_reset", instret_cnt, 32'd0);
`endif
    for (int v = 0; v < NV; v++) run_instr(vecs[v], v);
    check("no_flags_after_table", {29'd0, illegal, bus_err, halt}, 32'd0);
`ifdef SEQ_PERF_CNT_EN
    check("perf_cycle_total", cycle_cnt, 32'd68);
    check("perf_instret_total", instret_cnt, 32'd12);
`endif

    // Fetch never acknowledged: 16 wait cycles (count 0..15) then bus error.
    do_reset();
    i_delay = 100000;
    d_delay = 100000;
    n = 0;
    while (imem_req && n < 40) begin
      drive_acks();
      #3;
      n++;
      advance();
    end
    check("timeout_wait_cycles", 32'(n), 32'd16);
    #3;
    check("timeout_halt_state", 32'(outs()), 32'd3);
    bad = 0;
    repeat (20) begin
      advance();
      #3;
      if (outs() !== 15'd3) bad++;
    end
    check("timeout_sticky", 32'(bad), 32'd0);
    rst = 1'b1;
    advance();
    rst = 1'b0;
    #3;
    check("timeout_rst_clear", 32'(outs()), 32'd0);
    advance();
    #3;
    check("timeout_refetch", 32'(imem_req), 32'd1);

    // Illegal opcode halts with illegal set; fetch never resumes.
    do_reset();
    opcode = 7'b1111111;
    i_delay = 0;
    drive_acks();
    advance();
    drive_acks();
    #3;
    check("illegal_decode_quiet", 32'(outs()), 32'd0);
    advance();
    #3;
    check("illegal_halt", 32'(outs()), 32'd5);
    bad = 0;
    repeat (5) begin
      advance();
      #3;
      if (outs() !== 15'd5) bad++;
    end
    check("illegal_sticky", 32'(bad), 32'd0);

    // SYSTEM halts without flagging illegal.
    do_reset();
    opcode = 7'b1110011;
    drive_acks();
    advance();
    drive_acks();
    advance();
    #3;
    check("system_halt", 32'(outs()), 32'd1);

    // Reset while a store is waiting on dmem_ack.
    do_reset();
    opcode = 7'b0100011;
    i_delay = 0;
    d_delay = 100000;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      drive_acks();
      #3;
      if (dmem_req) found = 1;
      else advance();
    end
    check("mem_reached", 32'(found), 32'd1);
    check("mem_store_we", 32'(dmem_we), 32'd1);
    rst = 1'b1;
    dmem_ack = 1'b0;
    advance();
    rst = 1'b0;
    #3;
    check("rst_mem_outputs", 32'(outs()), 32'd0);
    advance();
    #3;
    check("rst_mem_refetch", 32'(imem_req), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_cycle_sequencer.md
Name: multi_cycle_sequencer

Overview:
- Control FSM that sequences the RV32I datapath (PC, instruction memory, register file, ALU, data memory) over multiple cycles per instruction.
- Issues phase strobes, mux selects and memory request handshakes.
- Sits beside the control unit. The control unit still decodes ALU_Ctrl, Mask and imm_select; this block owns *when* each datapath element is written.

Parameters:
- TIMEOUT, 15, maximum wait cycles for a memory ack before bus error.
- TO_W, 4, width of the timeout counter. Must hold TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  7  instruction register bits [6:0].
- br_taken  in  1  branch comparator result, valid in EXEC.
- imem_req  out  1  instruction fetch request.
- imem_ack  in  1  instruction valid/accepted.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  1 = store, 0 = load. Valid while dmem_req is high.
- dmem_ack  in  1  data access complete.
- ir_write  out  1  latch instruction register and old_pc.
- pc_write  out  1  update PC.
- pc_src  out  2  00 PC+4, 01 branch target, 10 JAL target, 11 JALR target.
- a_select  out  1  ALU A operand: 0 = rs1, 1 = old_pc.
- b_select  out  1  ALU B operand: 0 = rs2, 1 = immediate.
- reg_write  out  1  register file write enable.
- wd_src  out  2  write-data select: 00 ALU, 01 memory, 10 PC+4, 11 immediate.
- illegal  out  1  sticky, unsupported opcode.
- bus_err  out  1  sticky, memory timeout.
- halt  out  1  sticky, core stopped.

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. All outputs are decoded from the registered state plus the ack/br_taken inputs.
- Reset:
  - rst forces the state to IDLE and clears the sticky flags and the timeout counter.
  - In IDLE every output is 0, so the reset value of all outputs is 0.
  - IDLE goes to FETCH unconditionally.
- FETCH:
  - imem_req=1, held until imem_ack.
  - On the ack cycle: ir_write=1, pc_write=1, pc_src=00, then go to DECODE.
  - imem_ack outside FETCH is ignored.
- DECODE (1 cycle): classifies opcode.
  - SYSTEM (1110011) goes to HALT.
  - Any opcode outside {0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111} sets illegal=1 and goes to HALT.
  - All other opcodes go to EXEC.
- EXEC (1 cycle):
  - BRANCH: a_select=1, b_select=1. If br_taken, pc_write=1 with pc_src=01. Then go to FETCH.
  - JAL: pc_write=1, pc_src=10, go to WB.
  - JALR: pc_write=1, pc_src=11, go to WB.
  - LOAD/STORE: b_select=1, go to MEM.
  - R-type (b_select=0) and I-ALU (b_select=1): go to WB.
  - AUIPC: a_select=1, b_select=1, go to WB.
  - LUI: go to WB.
- MEM:
  - dmem_req=1, with dmem_we=1 for stores. Both held stable until dmem_ack.
  - On ack: store goes to FETCH, load goes to WB.
- WB (1 cycle): reg_write=1, then go to FETCH. wd_src is:
  - 01 for load.
  - 10 for JAL/JALR.
  - 11 for LUI.
  - 00 otherwise.
- Latency, with ack in the same cycle as req:
  - Branch: 3 cycles.
  - Store, ALU, jump: 4 cycles.
  - Load: 5 cycles.
- Timeout:
  - The counter increments each FETCH/MEM cycle without an ack and clears on ack or state exit.
  - A wait cycle with count == TIMEOUT sets bus_err=1 and goes to HALT.
  - An ack arriving in that same cycle wins: no error.
- HALT: all outputs 0 except halt and the sticky flags. Exit only via rst.
- Reset mid-operation (any state, including with req high): the next cycle is IDLE with all outputs 0. No partial write is issued.

Optional Feature:
- SEQ_PERF_CNT_EN defined: adds outputs cycle_cnt[31:0] and instret_cnt[31:0].
  - Both reset to 0.
  - cycle_cnt increments every non-IDLE, non-HALT cycle.
  - instret_cnt increments on the final cycle of each instruction (the transition into FETCH from EXEC, MEM or WB).
  - Both wrap modulo 2^32.
- SEQ_PERF_CNT_EN undefined: the ports and logic are absent. All other behaviour is identical.

Decomposition:
- Package seq_pkg holds:
  - the state encoding;
  - the RV32I opcode constants;
  - the pc_src and wd_src encodings;
  - the TIMEOUT default.
- One sub-module, seq_op_class: combinational opcode-to-class decoder (ALU_R, ALU_I, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM, ILLEGAL).

Test Plan:
1. Release rst, opcode=0110011, imem_ack high 1 cycle after req → states IDLE, FETCH, DECODE, EXEC, WB. reg_write=1 for exactly 1 cycle with wd_src=00, b_select=0 in EXEC.
2. opcode=0000011, dmem_ack asserted 3 cycles after dmem_req rises → dmem_req high for 4 cycles with dmem_we=0, then WB with wd_src=01.
3. opcode=1100011, br_taken=1 → pc_write=1, pc_src=01 in EXEC, no reg_write. Repeat with br_taken=0 → no pc_write in EXEC, 3-cycle instruction.
4. imem_ack held 0 → after 15 wait cycles bus_err=1 and halt=1, stable for 20 more cycles. A 1-cycle rst pulse → IDLE, flags cleared.
5. opcode=1111111 → illegal=1, halt=1 the cycle after DECODE, imem_req stays 0.
6. rst asserted during MEM with dmem_req=1 (store) → next cycle dmem_req=0, dmem_we=0, all outputs 0, then FETCH.
